// File: rtl/ahbl_excl_monitor.sv
// Exclusive-access monitor for one AHB-Lite slave port.
// Keeps one reservation per master, gates failed exclusive stores.
module ahbl_excl_monitor #(
    parameter int N_MASTERS    = 2,
    parameter int W_ADDR       = 32,
    parameter int GRANULE_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_hready,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic [1:0]        dst_htrans,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp
);

    localparam int IDXW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int TW   = W_ADDR - GRANULE_LOG2;

    // Reservation table
    logic [N_MASTERS-1:0] valid_q;
    logic [N_MASTERS-1:0] valid_d;
    logic [TW-1:0]        tag_q [N_MASTERS];
    logic [TW-1:0]        tag_d [N_MASTERS];

    // Data-phase tracking
    logic            dph_active_q;
    logic            dph_active_d;
    logic            dph_ok_q;
    logic            dph_ok_d;
    logic            dph_setv_q;
    logic            dph_setv_d;
    logic [IDXW-1:0] dph_setidx_q;
    logic [IDXW-1:0] dph_setidx_d;

    // Address-phase decode
    logic                 acc;
    logic                 id_valid;
    logic [IDXW-1:0]      idx;
    logic [TW-1:0]        tag;
    logic                 err_clr;
    logic [N_MASTERS-1:0] valid_e;
    logic [N_MASTERS-1:0] tag_hit;
    logic                 own_hit;
    logic                 excl_rd;
    logic                 excl_wr;
    logic                 xw_ok;
    logic                 xw_fail;
    logic                 plain_wr;

    assign acc      = src_hready & src_htrans[1];
    assign id_valid = ({24'd0, src_hmaster} < N_MASTERS);
    assign idx      = src_hmaster[IDXW-1:0];
    assign tag      = src_haddr[W_ADDR-1:GRANULE_LOG2];

    // An erroring exclusive read loses its reservation before the
    // current address phase is judged against the table.
    assign err_clr = dph_active_q & dph_setv_q
                   & dst_hresp & dst_hready_resp;

    // Table view with the data-phase error clear already applied
    always_comb begin
        valid_e = valid_q;
        if (err_clr) begin
            valid_e[dph_setidx_q] = 1'b0;
        end
    end

    // Per-entry granule match against the current address
    always_comb begin
        tag_hit = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            tag_hit[i] = valid_e[i] & (tag_q[i] == tag);
        end
    end

    assign own_hit  = id_valid & tag_hit[idx];
    assign excl_rd  = acc & src_hexcl & ~src_hwrite & id_valid;
    assign excl_wr  = acc & src_hexcl & src_hwrite;
    assign xw_ok    = excl_wr & own_hit;
    assign xw_fail  = excl_wr & ~own_hit;
    assign plain_wr = acc & ~src_hexcl & src_hwrite;

    // A failed exclusive store reaches the slave as IDLE
    assign dst_htrans = xw_fail ? 2'b00 : src_htrans;

    assign src_hexokay = dph_active_q & dph_ok_q & ~dst_hresp;

    // Table next state: error clear first, then the address action
    always_comb begin
        valid_d = valid_e;
        tag_d   = tag_q;
        if (excl_rd) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = tag;
        end
        if (xw_ok | plain_wr) begin
            valid_d = valid_d & ~tag_hit;
        end
        if (xw_fail & id_valid) begin
            valid_d[idx] = 1'b0;
        end
    end

    // Data-phase next state, advanced only when HREADY is high
    always_comb begin
        dph_active_d = dph_active_q;
        dph_ok_d     = dph_ok_q;
        dph_setv_d   = dph_setv_q;
        dph_setidx_d = dph_setidx_q;
        if (acc) begin
            dph_active_d = 1'b1;
            dph_ok_d     = excl_rd | xw_ok;
            dph_setv_d   = excl_rd;
            dph_setidx_d = idx;
        end else if (src_hready) begin
            dph_active_d = 1'b0;
            dph_ok_d     = 1'b0;
            dph_setv_d   = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            dph_active_q <= 1'b0;
            dph_ok_q     <= 1'b0;
            dph_setv_q   <= 1'b0;
            dph_setidx_q <= '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            dph_active_q <= dph_active_d;
            dph_ok_q     <= dph_ok_d;
            dph_setv_q   <= dph_setv_d;
            dph_setidx_q <= dph_setidx_d;
            for (int i = 0; i < N_MASTERS; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Bench for ahbl_excl_monitor: directed table, reset cases and
// random traffic against a reservation-rule reference model.
module tb_ahbl_excl_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_hready;
    logic [31:0] src_haddr;
    logic        src_hwrite;
    logic [1:0]  src_htrans;
    logic        src_hexcl;
    logic [7:0]  src_hmaster;
    logic        src_hexokay;
    logic [1:0]  dst_htrans;
    logic        dst_hready_resp;
    logic        dst_hresp;

    always #5 clk = ~clk;

    ahbl_excl_monitor #(
        .N_MASTERS(2),
        .W_ADDR(32),
        .GRANULE_LOG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_hready(src_hready),
        .src_haddr(src_haddr),
        .src_hwrite(src_hwrite),
        .src_htrans(src_htrans),
        .src_hexcl(src_hexcl),
        .src_hmaster(src_hmaster),
        .src_hexokay(src_hexokay),
        .dst_htrans(dst_htrans),
        .dst_hready_resp(dst_hready_resp),
        .dst_hresp(dst_hresp)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        bit          wr;
        bit          ex;
        logic [1:0]  ht;
        int          waits;
        bit          err;
        bit          chk;
        logic [1:0]  eht;
        bit          eok;
    } xf_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: reservations per master, granule = addr >> 2
    bit          mv   [2];
    logic [29:0] mtag [2];
    // Pending data phase of the last accepted transfer
    bit p_act, p_ok, p_set, p_err, p_chk, p_eok;
    int p_idx, p_waits;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, a, e, $time);
        end
    endtask

    function automatic xf_t mk(input int m, input logic [31:0] addr,
                               input bit wr, input bit ex,
                               input logic [1:0] ht, input int waits,
                               input bit err, input bit c,
                               input logic [1:0] eht, input bit eok);
        xf_t t;
        t.m = m; t.addr = addr; t.wr = wr; t.ex = ex; t.ht = ht;
        t.waits = waits; t.err = err; t.chk = c;
        t.eht = eht; t.eok = eok;
        return t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i]   = 1'b0;
            mtag[i] = '0;
        end
        p_act = 0; p_ok = 0; p_set = 0; p_err = 0;
        p_chk = 0; p_eok = 0; p_idx = 0; p_waits = 0;
    endfunction

    function automatic void drop_granule(input logic [29:0] g);
        for (int i = 0; i < 2; i++) begin
            if (mv[i] && mtag[i] == g) mv[i] = 1'b0;
        end
    endfunction

    // One address phase of t, overlapping the previous data phase
    task automatic run_xf(input xf_t t);
        int          n;
        bit          rdy, resp, acc, idv, own, ok, setr;
        logic [29:0] g;
        logic [1:0]  eht;
        bit          keep [2];
        n = p_waits + (p_err ? 2 : 1);
        g = t.addr[31:2];
        for (int c = 0; c < n; c++) begin
            if (c < p_waits) begin
                rdy = 0; resp = 0;
            end else if (p_err) begin
                resp = 1; rdy = (c == n - 1);
            end else begin
                rdy = 1; resp = 0;
            end
            @(negedge clk);
            src_haddr       = t.addr;
            src_hwrite      = t.wr;
            src_hexcl       = t.ex;
            src_htrans      = t.ht;
            src_hmaster     = 8'(t.m);
            src_hready      = rdy;
            dst_hready_resp = rdy;
            dst_hresp       = resp;
            #1;
            keep = mv;
            if (p_act && p_set && resp && rdy) keep[p_idx] = 1'b0;
            acc = rdy && t.ht[1];
            idv = (t.m >= 0) && (t.m < 2);
            own = idv ? (keep[t.m] && mtag[t.m] == g) : 1'b0;
            eht = (acc && t.ex && t.wr && !own) ? 2'b00 : t.ht;
            chk("htrans", {30'd0, dst_htrans}, {30'd0, eht});
            chk("hexokay", {31'd0, src_hexokay},
                {31'd0, p_act && p_ok && !resp});
            if (t.chk && acc)
                chk("tbl_htrans", {30'd0, dst_htrans}, {30'd0, t.eht});
            if (p_chk && !resp)
                chk("tbl_hexokay", {31'd0, src_hexokay}, {31'd0, p_eok});
            if (rdy) begin
                mv = keep;
                ok = 0;
                setr = 0;
                if (acc && t.ex && !t.wr) begin
                    if (idv) begin
                        mv[t.m] = 1'b1;
                        mtag[t.m] = g;
                        ok = 1;
                        setr = 1;
                    end
                end else if (acc && t.ex && t.wr) begin
                    if (own) begin
                        drop_granule(g);
                        ok = 1;
                    end else if (idv) begin
                        mv[t.m] = 1'b0;
                    end
                end else if (acc && t.wr) begin
                    drop_granule(g);
                end
                p_act   = acc;
                p_ok    = ok;
                p_set   = setr;
                p_idx   = idv ? t.m : 0;
                p_waits = acc ? t.waits : 0;
                p_err   = acc ? t.err : 1'b0;
                p_chk   = acc && t.chk;
                p_eok   = t.eok;
            end
        end
    endtask

    // Reset with a stale exclusive write presented but not accepted
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        src_hready      = 1'b0;
        dst_hready_resp = 1'b0;
        dst_hresp       = 1'b0;
        src_htrans      = 2'b10;
        src_hexcl       = 1'b1;
        src_hwrite      = 1'b1;
        src_hmaster     = 8'd0;
        src_haddr       = 32'h400;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hexokay", {31'd0, src_hexokay}, 32'd0);
            chk("rst_htrans", {30'd0, dst_htrans}, 32'd2);
        end
        @(negedge clk);
        rst             = 1'b0;
        src_htrans      = 2'b00;
        src_hready      = 1'b1;
        dst_hready_resp = 1'b1;
        model_reset();
    endtask

    xf_t tbl [$];
    xf_t idle;
    logic [31:0] pool [4];

    initial begin
        rst = 1'b1;
        src_hready = 1'b1; src_haddr = '0; src_hwrite = 1'b0;
        src_htrans = 2'b00; src_hexcl = 1'b0; src_hmaster = '0;
        dst_hready_resp = 1'b1; dst_hresp = 1'b0;
        model_reset();
        idle = mk(0, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
        pool[0] = 32'h100; pool[1] = 32'h104;
        pool[2] = 32'h200; pool[3] = 32'h300;

        // m, addr, wr, ex, htrans, waits, err, chk, exp htrans, exp ok
        tbl.push_back(mk(0, 32'h100, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(0, 32'h100, 1, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(0, 32'h100, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk(0, 32'h100, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(1, 32'h102, 1, 0, 2'b10, 0, 0, 1, 2'b10, 0));
        tbl.push_back(mk(0, 32'h100, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk(0, 32'h100, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(1, 32'h100, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(1, 32'h100, 1, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(0, 32'h100, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk(0, 32'h200, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 32'h200, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(5, 32'h300, 0, 1, 2'b10, 0, 0, 1, 2'b10, 0));
        tbl.push_back(mk(1, 32'h200, 1, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        tbl.push_back(mk(0, 32'h300, 0, 1, 2'b10, 3, 1, 1, 2'b10, 1));
        tbl.push_back(mk(0, 32'h300, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));

        do_reset();
        foreach (tbl[i]) run_xf(tbl[i]);
        run_xf(idle);

        // Reservation killed by reset, including mid data phase
        run_xf(mk(0, 32'h400, 0, 1, 2'b10, 0, 0, 1, 2'b10, 1));
        run_xf(mk(0, 32'h400, 0, 1, 2'b10, 1, 0, 1, 2'b10, 1));
        do_reset();
        run_xf(mk(0, 32'h400, 1, 1, 2'b10, 0, 0, 1, 2'b00, 0));
        run_xf(idle);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            xf_t t;
            int  r;
            r = $urandom_range(0, 9);
            t = idle;
            t.m = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 1);
            t.addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            t.ht = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 :
                   (r < 7) ? 2'b10 : 2'b11;
            t.wr = $urandom_range(0, 1) != 0;
            t.ex = $urandom_range(0, 2) != 0;
            t.waits = $urandom_range(0, 2);
            t.err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            run_xf(t);
        end
        run_xf(idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
